// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pending-load scoreboard driving IF/ID and ID/EX stall/flush controls
module hazard_scoreboard #(
    parameter int REG_ADDR_W  = 5,
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             id_valid,
    input  logic                             id_memread,
    input  logic [REG_ADDR_W-1:0]            rs1_id,
    input  logic [REG_ADDR_W-1:0]            rs2_id,
    input  logic                             rs1_used,
    input  logic                             rs2_used,
    input  logic [REG_ADDR_W-1:0]            rd_id,
    input  logic                             wb_valid,
    input  logic [REG_ADDR_W-1:0]            wb_rd,
    input  logic                             branch_taken,
    output logic                             stall,
    output logic                             flush_if_id,
    output logic                             flush_id_ex,
    output logic [$clog2(MAX_PENDING+1)-1:0] outstanding,
    output logic                             pending_full,
    output logic [CNT_W-1:0]                 stall_count,
    output logic [CNT_W-1:0]                 flush_count
);
    localparam int NUM_REGS = 2**REG_ADDR_W;
    localparam int OUT_W    = $clog2(MAX_PENDING+1);

    logic [NUM_REGS-1:0] pending_q, pending_d, eff;
    logic [OUT_W-1:0]    outstanding_q, outstanding_d;
    logic [CNT_W-1:0]    stall_count_q, stall_count_d, flush_count_q, flush_count_d;
    logic                wb_hit, raw_hz, waw_hz, cap_hz, hz, issue;

    // Hazard detection, pipeline controls and next-state of scoreboard and counters
    always_comb begin
        eff = pending_q;
        if (wb_valid) eff[wb_rd] = 1'b0;
        wb_hit = wb_valid & pending_q[wb_rd];
        raw_hz = id_valid & ((rs1_used & (rs1_id != '0) & eff[rs1_id]) |
                             (rs2_used & (rs2_id != '0) & eff[rs2_id]));
        waw_hz = id_valid & id_memread & (rd_id != '0) & eff[rd_id];
        cap_hz = id_valid & id_memread & pending_full & ~wb_hit;
        hz = raw_hz | waw_hz | cap_hz;
        stall = ~branch_taken & hz;
        flush_if_id = branch_taken;
        flush_id_ex = branch_taken | hz;
        issue = id_valid & id_memread & (rd_id != '0) & ~hz & ~branch_taken;
        pending_d = pending_q;
        if (wb_hit) pending_d[wb_rd] = 1'b0;
        if (issue) pending_d[rd_id] = 1'b1;
        pending_d[0] = 1'b0;
        outstanding_d = outstanding_q + OUT_W'(issue) - OUT_W'(wb_hit);
        stall_count_d = stall_count_q + CNT_W'(stall & ~(&stall_count_q));
        flush_count_d = flush_count_q + CNT_W'(branch_taken & ~(&flush_count_q));
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q     <= '0;
            outstanding_q <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign outstanding  = outstanding_q;
    assign pending_full = outstanding_q == OUT_W'(MAX_PENDING);
    assign stall_count  = stall_count_q;
    assign flush_count  = flush_count_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: scoreboard bench with a set-based reference model
module tb_hazard_scoreboard;
    localparam int AW = 5;
    localparam int MP = 4;
    localparam int CW = 5;
    localparam int OW = $clog2(MP+1);
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic id_valid = 1'b0, id_memread = 1'b0, rs1_used = 1'b0, rs2_used = 1'b0;
    logic wb_valid = 1'b0, branch_taken = 1'b0;
    logic [AW-1:0] rs1_id = '0, rs2_id = '0, rd_id = '0, wb_rd = '0;
    logic stall, flush_if_id, flush_id_ex, pending_full;
    logic [OW-1:0] outstanding;
    logic [CW-1:0] stall_count, flush_count;

    hazard_scoreboard #(.REG_ADDR_W(AW), .MAX_PENDING(MP), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_memread(id_memread),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rd_id(rd_id), .wb_valid(wb_valid), .wb_rd(wb_rd), .branch_taken(branch_taken),
        .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .outstanding(outstanding), .pending_full(pending_full),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          st, fif, fex;
        logic [OW-1:0] outs;
        logic          full;
        logic [CW-1:0] sc, fc;
    } exp_t;

    exp_t exp_q[$];
    int tests = 0, fails = 0, cyc = 0;

    // Reference model: the set of registers awaiting load data, plus counter values
    bit pend[int];
    int m_sc = 0, m_fc = 0;

    function automatic bit effp(int r, bit wv, int wr);
        return pend.exists(r) && !(wv && wr == r);
    endfunction

    task automatic step(input bit rn, input bit iv, input bit mr, input int r1, input int r2,
                        input bit u1, input bit u2, input int rd, input bit wv, input int wr,
                        input bit br);
        bit raw, waw, hit, cap, hz, iss;
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rn; id_valid = iv; id_memread = mr; rs1_id = AW'(r1); rs2_id = AW'(r2);
        rs1_used = u1; rs2_used = u2; rd_id = AW'(rd); wb_valid = wv; wb_rd = AW'(wr);
        branch_taken = br;
        raw = iv && ((u1 && r1 != 0 && effp(r1, wv, wr)) || (u2 && r2 != 0 && effp(r2, wv, wr)));
        waw = iv && mr && rd != 0 && effp(rd, wv, wr);
        hit = wv && pend.exists(wr);
        cap = iv && mr && pend.num() == MP && !hit;
        hz  = raw || waw || cap;
        iss = iv && mr && rd != 0 && !hz && !br;
        e.st = !br && hz; e.fif = br; e.fex = br || hz;
        e.outs = OW'(pend.num()); e.full = pend.num() == MP;
        e.sc = CW'(m_sc); e.fc = CW'(m_fc);
        exp_q.push_back(e);
        if (!rn) begin
            pend.delete(); m_sc = 0; m_fc = 0;
        end else begin
            if (hit) pend.delete(wr);
            if (iss) pend[rd] = 1'b1;
            if (e.st && m_sc < CMAX) m_sc++;
            if (br && m_fc < CMAX) m_fc++;
        end
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load(input int rd, input bit wv, input int wr);
        step(1, 1, 1, 0, 0, 0, 0, rd, wv, wr, 0);
    endtask

    task automatic wb(input int wr);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, wr, 0);
    endtask

    // Monitor: compare the DUT against the oldest pending expectation each cycle
    exp_t got, want;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = '{stall, flush_if_id, flush_id_ex, outstanding, pending_full, stall_count, flush_count};
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL cycle %0d: got st/fif/fex=%b%b%b out=%0d full=%b sc=%0d fc=%0d, want st/fif/fex=%b%b%b out=%0d full=%b sc=%0d fc=%0d",
                         cyc, got.st, got.fif, got.fex, got.outs, got.full, got.sc, got.fc,
                         want.st, want.fif, want.fex, want.outs, want.full, want.sc, want.fc);
            end
            cyc++;
        end
    end

    initial begin
        // Reset with arbitrary inputs, then idle with id_valid=0
        step(0, 1, 1, 5, 6, 1, 1, 7, 1, 3, 1);
        step(0, 0, 1, 2, 3, 1, 1, 4, 0, 0, 0);
        idle();
        // Multi-cycle load-use on x5, released by same-cycle writeback
        load(5, 0, 0);
        repeat (3) step(1, 1, 0, 5, 0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 5, 0, 1, 0, 0, 1, 5, 0);
        idle();
        // Load to x0 is ignored; unused rs2 never stalls
        load(0, 0, 0);
        load(7, 0, 0);
        step(1, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 7, 0, 1, 0, 0, 0, 0);
        wb(7);
        // Capacity limit and release by a same-cycle writeback
        for (int r = 1; r <= 4; r++) load(r, 0, 0);
        load(9, 0, 0);
        load(9, 1, 2);
        idle();
        for (int r = 1; r <= 9; r++) wb(r);
        // Branch priority over a RAW hazard; a load under the branch is killed
        load(5, 0, 0);
        step(1, 1, 0, 5, 0, 1, 0, 0, 0, 0, 1);
        step(1, 1, 1, 0, 0, 0, 0, 8, 0, 0, 1);
        idle();
        // WAW with same-cycle writeback of the same register; stray writeback
        load(6, 0, 0);
        load(6, 1, 6);
        idle();
        wb(12);
        load(6, 0, 0);
        // Mid-operation reset forgets pending loads
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 5, 6, 1, 1, 6, 0, 0, 0);
        // Saturation of both counters
        load(3, 0, 0);
        repeat (40) step(1, 1, 0, 3, 0, 1, 0, 0, 0, 0, 0);
        repeat (40) step(1, 1, 0, 3, 0, 1, 0, 0, 0, 0, 1);
        wb(3);
        // Randomized traffic over a narrow register range to provoke hazards
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 59) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 1),
                 $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1), $urandom_range(0, 9), $urandom_range(0, 4) < 2,
                 $urandom_range(0, 9), $urandom_range(0, 9) == 0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised next-generation hazard unit for the RISC-V pipeline, used when data memory has variable latency.
- Replaces fixed one-cycle load-use detection with a per-register pending-write scoreboard that is set at load issue and cleared at load writeback.
- Keeps the existing stall/flush contract: branch flush has priority over stall; a load-use stall bubbles ID/EX.
- Adds outstanding-load limiting and saturating stall/flush performance counters. Sits beside the ID stage and drives the IF/ID and ID/EX pipeline-register controls.

Parameters:
- REG_ADDR_W, 5, register index width; NUM_REGS = 2**REG_ADDR_W.
- MAX_PENDING, 4, maximum outstanding loads (1..NUM_REGS-1).
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  ID stage holds a valid instruction.
- id_memread  in  1  ID instruction is a load.
- rs1_id  in  REG_ADDR_W  ID source 1.
- rs2_id  in  REG_ADDR_W  ID source 2.
- rs1_used  in  1  ID instruction reads rs1.
- rs2_used  in  1  ID instruction reads rs2.
- rd_id  in  REG_ADDR_W  ID destination.
- wb_valid  in  1  load data written back this cycle.
- wb_rd  in  REG_ADDR_W  destination of returning load.
- branch_taken  in  1  branch/jump resolved taken in EX.
- stall  out  1  hold PC and IF/ID.
- flush_if_id  out  1  bubble IF/ID.
- flush_id_ex  out  1  bubble ID/EX.
- outstanding  out  $clog2(MAX_PENDING+1)  pending loads count.
- pending_full  out  1  outstanding == MAX_PENDING.
- stall_count  out  CNT_W  cycles with stall=1.
- flush_count  out  CNT_W  cycles with branch flush.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n): all state updates on the rising edge of clk while rst_n=0.
- Reset values: pending vector = 0, outstanding = 0, stall_count = 0, flush_count = 0. Combinational outputs follow from the cleared state.
- State: pending[NUM_REGS-1:0]. Bit 0 (x0) is never set.
- Effective pending, used combinationally: eff[r] = pending[r] & ~(wb_valid & wb_rd==r). The same-cycle writeback bypass relies on the register-file write-through.
- Hazard:
  - raw_hz = id_valid & ((rs1_used & rs1_id!=0 & eff[rs1_id]) | (rs2_used & rs2_id!=0 & eff[rs2_id])).
  - waw_hz = id_valid & id_memread & rd_id!=0 & eff[rd_id].
  - cap_hz = id_valid & id_memread & pending_full & ~(wb_valid & pending[wb_rd]).
  - hz = raw_hz | waw_hz | cap_hz.
- Outputs (combinational, zero latency):
  - branch_taken=1: stall=0, flush_if_id=1, flush_id_ex=1. Branch has priority over any hazard.
  - else hz=1: stall=1, flush_id_ex=1, flush_if_id=0.
  - else: all three outputs 0.
- Issue: issue = id_valid & id_memread & rd_id!=0 & ~hz & ~branch_taken. On the clock edge, issue sets pending[rd_id].
- Clear: on the clock edge, wb_valid & pending[wb_rd] clears pending[wb_rd]. A wb_valid to a non-pending register (or x0) is ignored and leaves outstanding unchanged.
- Same register set and cleared in one cycle: set wins and the bit stays 1.
- outstanding next value = outstanding + issue - valid_clear. A simultaneous issue and clear leaves it unchanged. It can never exceed MAX_PENDING. pending_full = (outstanding == MAX_PENDING).
- Counters:
  - stall_count increments when stall=1.
  - flush_count increments when branch_taken=1.
  - Both saturate at all-ones and never wrap.
- Reset mid-operation: all pending loads are forgotten in the same edge. The following cycle shows no hazards.
- Loads already past ID are never cancelled by branch_taken; only the ID instruction is killed.

Test Plan:
- Reset: rst_n=0 for 2 cycles with arbitrary inputs -> outstanding=0, stall_count=0; with id_valid=0, stall, flush_if_id and flush_id_ex are all 0.
- Multi-cycle load-use: issue load x5, no wb for 3 cycles, ID reads rs1=x5 -> stall=1, flush_id_ex=1, flush_if_id=0 for 3 cycles. Assert wb_valid, wb_rd=5 -> stall=0 that same cycle; stall_count=3.
- x0 and unused operands: load to x0 -> outstanding stays 0. Pending x7 with rs2_id=7, rs2_used=0 -> stall=0.
- Capacity: issue loads to x1..x4 (MAX_PENDING=4) -> pending_full=1. Fifth load to x9 -> stall=1. Same cycle wb_rd=2 -> no stall, outstanding remains 4.
- Branch priority: pending x5, ID reads x5, branch_taken=1 -> stall=0, flush_if_id=1, flush_id_ex=1, flush_count+1. An ID load issued under the branch does not set pending.
- WAW and set/clear collision: pending x6, ID load to x6 with wb_rd=6 same cycle -> no stall, pending[6] remains 1, outstanding unchanged. A stray wb_rd=12 with no pending load -> outstanding unchanged.
